// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: steps a one-bit ALU slice across WIDTH-bit
// operands, LSB first, feeding the carry back between bits. Presents a
// start/busy/done handshake and registered result, carry-out and zero flags.
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_sh_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;

    logic             sub_s;
    logic             bp_s;
    logic             sum_s;
    logic             carry_nxt_s;
    logic             bit_s;
    logic             last_s;
    logic [WIDTH-1:0] shifted_s;
    logic [WIDTH-1:0] final_s;
    logic             cout_nxt_s;

    // Majority of three bits: the carry out of a full adder.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // SUB and SLT share the subtract datapath (inverted b, carry-in of 1).
    function automatic logic is_sub_op(input logic [2:0] o);
        return (o == 3'b110) || (o == 3'b111);
    endfunction

    // One-bit ALU slice plus completion values for the current bit position.
    always_comb begin
        sub_s       = is_sub_op(op_r);
        bp_s        = sub_s ? ~b_r[0] : b_r[0];
        sum_s       = a_r[0] ^ bp_s ^ carry_r;
        carry_nxt_s = maj3(a_r[0], bp_s, carry_r);
        case (op_r)
            3'b000:  bit_s = a_r[0] & b_r[0];
            3'b001:  bit_s = a_r[0] | b_r[0];
            3'b010:  bit_s = sum_s;
            3'b011:  bit_s = a_r[0] ^ b_r[0];
            3'b100:  bit_s = ~(a_r[0] & b_r[0]);
            3'b101:  bit_s = ~(a_r[0] | b_r[0]);
            3'b110:  bit_s = sum_s;
            default: bit_s = 1'b0;
        endcase
        shifted_s = {bit_s, res_sh_r[WIDTH-1:1]};
        last_s    = (cnt_r == CW'(WIDTH - 1));
        // SLT: signed less-than is MSB sum XOR overflow (carry-in ^ carry-out).
        if (op_r == 3'b111) begin
            final_s = {{(WIDTH-1){1'b0}}, sum_s ^ (carry_r ^ carry_nxt_s)};
        end else begin
            final_s = shifted_s;
        end
        if ((op_r == 3'b010) || (op_r == 3'b110)) begin
            cout_nxt_s = carry_nxt_s;
        end else begin
            cout_nxt_s = 1'b0;
        end
    end

    // Sequencer FSM with operand shifters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= S_IDLE;
            op_r     <= 3'b000;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            res_sh_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            carry_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= {WIDTH{1'b0}};
            cout     <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_r     <= op;
                        a_r      <= a;
                        b_r      <= b;
                        res_sh_r <= {WIDTH{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        carry_r  <= is_sub_op(op);
                        busy     <= 1'b1;
                        state_r  <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_r      <= {1'b0, a_r[WIDTH-1:1]};
                    b_r      <= {1'b0, b_r[WIDTH-1:1]};
                    res_sh_r <= shifted_s;
                    carry_r  <= carry_nxt_s;
                    if (last_s) begin
                        result  <= final_s;
                        cout    <= cout_nxt_s;
                        zero    <= (final_s == {WIDTH{1'b0}});
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= S_RUN;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed self-checking bench for bit_serial_alu_ctrl (WIDTH=8).
module tb_bit_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;

    int checks;
    int errors;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a start for one edge, then count edges until done (bounded).
    // Returns latency in edges after acceptance (0 = timeout) and busy seen
    // #1 after the accepting edge. Caller must be in an IDLE cycle.
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, output int lat,
                          output logic busy_after);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_after = busy;
        a = 8'h00; b = 8'h00; op = 3'b000;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; op = 3'b010; a = 8'h11; b = 8'h22;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, cout, zero} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h cout=%b zero=%b, want all 0",
                     busy, done, result, cout, zero);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_start: busy=%b want 0", busy);
        end
    endtask

    task automatic test_add();
        int lat;
        logic bz;
        run_op(3'b010, 8'hFF, 8'h01, lat, bz);
        checks++;
        if (bz !== 1'b1) begin
            errors++; $display("FAIL add_busy: busy=%b want 1", bz);
        end
        checks++;
        if (lat != 8) begin
            errors++; $display("FAIL add_latency: got %0d want 8", lat);
        end
        checks++;
        if ({result, cout, zero} !== {8'h00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL add_ff_01: result=%h cout=%b zero=%b want 00 1 1", result, cout, zero);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++; $display("FAIL add_done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (result !== 8'h00 || cout !== 1'b1) begin
            errors++; $display("FAIL add_hold: result=%h cout=%b want 00 1", result, cout);
        end
    endtask

    task automatic test_sub_slt();
        logic [2:0] ops [6] = '{3'b110, 3'b110, 3'b111, 3'b111, 3'b111, 3'b110};
        logic [7:0] as  [6] = '{8'h07, 8'h05, 8'h80, 8'h7F, 8'h03, 8'h00};
        logic [7:0] bs  [6] = '{8'h05, 8'h07, 8'h01, 8'h80, 8'h03, 8'h00};
        logic [7:0] er  [6] = '{8'h02, 8'hFE, 8'h01, 8'h00, 8'h00, 8'h00};
        logic       ec  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       ez  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int lat;
        logic bz;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            run_op(ops[i], as[i], bs[i], lat, bz);
            checks++;
            if (lat != 8 || {result, cout, zero} !== {er[i], ec[i], ez[i]}) begin
                errors++;
                $display("FAIL sub_slt[%0d] op=%b a=%h b=%h: lat=%0d result=%h cout=%b zero=%b want lat=8 %h %b %b",
                         i, ops[i], as[i], bs[i], lat, result, cout, zero, er[i], ec[i], ez[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
        logic [7:0] er  [5] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03};
        int lat;
        logic bz;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], 8'hF0, 8'h3C, lat, bz);
            checks++;
            if (lat != 8 || result !== er[i] || cout !== 1'b0 || zero !== 1'b0) begin
                errors++;
                $display("FAIL logic[%0d] op=%b: lat=%0d result=%h cout=%b zero=%b want lat=8 %h 0 0",
                         i, ops[i], lat, result, cout, zero, er[i]);
            end
            // DONE cycle -> first IDLE cycle; next start accepted on the following edge.
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL b2b_idle[%0d]: busy=%b want 0", i, busy);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        op = 3'b010; a = 8'h10; b = 8'h20; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 24; n++) begin
            if (n >= 3 && n <= 5) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'b001;
            end else begin
                start = 1'b0; a = 8'h00; b = 8'h00; op = 3'b000;
            end
            @(posedge clk); #1;
            if (done) dones++;
            if (n == 4) begin
                checks++;
                if (result !== 8'h03) begin
                    errors++; $display("FAIL result_stable: result=%h want 03", result);
                end
            end
        end
        checks++;
        if (dones != 1) begin
            errors++; $display("FAIL ignore_dones: got %0d want 1", dones);
        end
        checks++;
        if (result !== 8'h30 || cout !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ignore_result: result=%h cout=%b busy=%b want 30 0 0", result, cout, busy);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        logic bz;
        op = 3'b010; a = 8'h55; b = 8'h0F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, cout, zero} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b result=%h cout=%b zero=%b want all 0",
                     busy, done, result, cout, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b010, 8'h01, 8'h01, lat, bz);
        checks++;
        if (lat != 8 || result !== 8'h02 || cout !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_add: lat=%0d result=%h cout=%b zero=%b want 8 02 0 0",
                     lat, result, cout, zero);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;
        test_reset();
        test_add();
        test_sub_slt();
        test_back_to_back();
        test_start_ignored();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
Sequencer that drives a one-bit ALU slice across WIDTH-bit operands, processing one bit per clock from LSB to MSB. The carry is fed back between bits.
Provides a start/busy/done handshake, a registered result, a carry-out flag and a zero flag. It lets the team's single-bit ALU serve as a compact multi-bit execution unit for area-constrained paths.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  3  operation code; latched on accepted start
a  input  WIDTH  operand A; latched on accepted start
b  input  WIDTH  operand B; latched on accepted start
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  registered result; holds until the next completion
cout  output  1  final carry for ADD/SUB, else 0
zero  output  1  high when the completed result is all zeros

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, result=0, cout=0, zero=0. Internal bit counter, carry and shift registers are cleared. Any in-flight operation is discarded. Reset wins over a simultaneous start.
- Op encoding (per bit i):
  - 000 AND: a&b
  - 001 OR: a|b
  - 010 ADD: a^b^c
  - 011 XOR: a^b
  - 100 NAND: ~(a&b)
  - 101 NOR: ~(a|b)
  - 110 SUB: a + ~b + c
  - 111 SLT: signed a<b
- Carry register:
  - Initialised on start to 1 for op 110/111, else 0.
  - Updated each bit with majority(a_i, b'_i, c), where b' = ~b for 110/111, else b.
  - Ignored for logic ops.
- FSM states and transitions:
  - IDLE: start=1 at edge k latches a, b, op; sets bit counter=0; goes to RUN; busy rises after edge k. start=0 stays in IDLE.
  - RUN: edges k+1..k+WIDTH each process bit[counter] and shift the result bit into the MSB of the result shift register; counter increments. At edge k+WIDTH, when bit WIDTH-1 has been processed, result/cout/zero are loaded into the output registers, done=1, and the state goes to DONE.
  - DONE: lasts exactly one cycle. At the next edge: done=0, state=IDLE, busy=0.
- Timing:
  - Start-accept to done-high latency is WIDTH edges.
  - Earliest next accepted start is edge k+WIDTH+2 (first IDLE cycle).
- start while busy (RUN or DONE) is ignored. It is not queued and does not change latched operands.
- Input changes on a/b/op after acceptance have no effect.
- cout:
  - ADD: carry out of bit WIDTH-1.
  - SUB: carry out of bit WIDTH-1, so 1 means no borrow (a>=b unsigned).
  - Logic ops and SLT: 0.
- SLT: run the SUB datapath serially. At the MSB, compute less = sum_msb XOR overflow, where overflow = carry-in(MSB) XOR carry-out(MSB). Result = {0…0, less}.
- zero: computed from the final result value, loaded together with result.
- result, cout and zero change only at the completion edge or on reset. They are stable in all other cycles.
- Counter must not wrap: exactly WIDTH bit-cycles per operation for any WIDTH.

Test Plan:
- WIDTH=8, ADD a=0xFF b=0x01, start pulsed one cycle. Expect:
  - busy high the next cycle;
  - done high exactly 8 edges after acceptance, for 1 cycle;
  - result=0x00, cout=1, zero=1.
- SUB cases:
  - a=0x07 b=0x05 -> result=0x02, cout=1, zero=0.
  - a=0x05 b=0x07 -> result=0xFE, cout=0.
- SLT cases:
  - a=0x80 b=0x01 -> result=0x01.
  - a=0x7F b=0x80 (overflow case) -> result=0x00.
  - a=0x03 b=0x03 -> result=0x00, zero=1, cout=0.
- Logic ops on a=0xF0 b=0x3C, run back-to-back at the earliest legal start:
  - AND -> 0x30
  - OR -> 0xFC
  - XOR -> 0xCC
  - NAND -> 0xCF
  - NOR -> 0x03
  - cout=0 for all.
- ADD a=0x10 b=0x20 started; start re-pulsed mid-RUN with a=0xFF and rst held 0. Expect a single done, result=0x30, and no second operation.
- rst asserted asynchronously after 4 RUN cycles. Expect:
  - busy=done=result=cout=zero=0 immediately, with no clock edge needed;
  - a following start with ADD 0x01+0x01 -> result=0x02 after 8 edges.
